// File: rtl/axis_pkt_arbiter.sv
// Round-robin AXI-stream packet arbiter: merges N byte-wide requesters into one
// stream, holding each grant until a tlast beat or MAX_BEATS forces the packet end.
module axis_pkt_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [8*N-1:0]       i_tdata,
  input  logic [N-1:0]         i_tlast,
  input  logic [N-1:0]         i_tvalid,
  output logic [N-1:0]         o_tready,
  output logic [7:0]           o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 i_tready,
  output logic [$clog2(N)-1:0] o_tid,
  output logic                 o_trunc
);

  localparam int          IW       = $clog2(N);
  localparam logic [15:0] LAST_CNT = 16'(MAX_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [IW-1:0]   cand;

  // grant_q doubles as last_grant while idle, so the search starts just after it
  always_comb begin
    pick     = grant_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(grant_q) + i) % N);
      if (!pick_vld && i_tvalid[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    o_tready = '0;
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    o_trunc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        o_tvalid          = i_tvalid[grant_q];
        o_tdata           = i_tdata[{grant_q, 3'b000} +: 8];
        o_tlast           = i_tlast[grant_q] | (cnt_q == LAST_CNT);
        o_tready[grant_q] = i_tready;
        if (o_tvalid && i_tready) begin
          cnt_d = cnt_q + 16'd1;
          // A forced end leaves the remainder of the packet to re-arbitrate
          o_trunc = o_tlast & ~i_tlast[grant_q];
          if (o_tlast) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_tid = grant_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a grant-level reference model and a per-requester scoreboard.
module tb_axis_pkt_arbiter;

  localparam int N     = 4;
  localparam int MAXB  = 4;
  localparam int IW    = $clog2(N);
  localparam int DEPTH = 512;

  logic           clk = 1'b0;
  logic           rstN;
  logic [8*N-1:0] iTdata;
  logic [N-1:0]   iTlast, iTvalid, oTready;
  logic [7:0]     oTdata;
  logic           oTlast, oTvalid, iTready, oTrunc;
  logic [IW-1:0]  oTid;

  axis_pkt_arbiter #(.N(N), .MAX_BEATS(MAXB)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_tdata(iTdata), .i_tlast(iTlast),
    .i_tvalid(iTvalid), .o_tready(oTready), .o_tdata(oTdata), .o_tlast(oTlast),
    .o_tvalid(oTvalid), .i_tready(iTready), .o_tid(oTid), .o_trunc(oTrunc)
  );

  always #5 clk = ~clk;

  // Requester sources: {tlast, data} beats, popped on each accepted handshake
  logic [8:0] srcMem [N][DEPTH];
  int head [N];
  int tail [N];
  int gapPct, readyMode;
  logic readyToggle;

  int compared = 0;
  int mismatched = 0;
  int cycleNo = 0;

  // Reference model: who owns the output (-1 = nobody), last grant, beats in grant
  int mOwner, mLastGrant, mCnt;

  int         pktStarts[$];
  int         xferTid[$];
  int         xferCycle[$];
  logic [7:0] xferData[$];
  logic       xferLast[$];
  int         truncCount;
  logic       prevLast;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rrPick(input int last, input logic [N-1:0] v);
    for (int d = 1; d <= N; d++) begin
      if (v[(last + d) % N]) return (last + d) % N;
    end
    return -1;
  endfunction

  function automatic bit drained();
    for (int k = 0; k < N; k++) if (head[k] != tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pushPacket(input int k, input int len, input bit randData, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      srcMem[k][tail[k]] = {(i == len - 1), randData ? 8'($urandom_range(0, 255)) : 8'(base + i)};
      tail[k]++;
    end
  endtask

  task automatic clearSources();
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
  endtask

  task automatic clearLog();
    pktStarts.delete(); xferTid.delete(); xferCycle.delete();
    xferData.delete(); xferLast.delete();
    truncCount = 0;
    prevLast   = 1'b1;
  endtask

  task automatic modelReset();
    mOwner     = -1;
    mLastGrant = N - 1;
    mCnt       = 0;
  endtask

  // Drive every requester from its source queue on the falling edge
  task automatic applyStimulus();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (head[k] < tail[k] && $urandom_range(0, 99) >= gapPct) begin
        iTvalid[k]        = 1'b1;
        iTdata[8*k +: 8]  = srcMem[k][head[k]][7:0];
        iTlast[k]         = srcMem[k][head[k]][8];
      end else begin
        iTvalid[k]        = 1'b0;
        iTdata[8*k +: 8]  = 8'($urandom_range(0, 255));
        iTlast[k]         = 1'($urandom_range(0, 1));
      end
    end
    case (readyMode)
      1:       iTready = ($urandom_range(0, 3) != 0);
      2: begin
        iTready     = readyToggle;
        readyToggle = ~readyToggle;
      end
      default: iTready = 1'b1;
    endcase
  endtask

  // Compare outputs with the model, log transfers and retire accepted beats
  task automatic checkOutput();
    logic [N-1:0] expReady;
    logic expValid, expLast, expTrunc;
    int   expTid, k;
    expReady = '0;
    expValid = 1'b0;
    expLast  = 1'b0;
    expTrunc = 1'b0;
    expTid   = mLastGrant;
    if (mOwner >= 0) begin
      expTid           = mOwner;
      expValid         = iTvalid[mOwner];
      expReady[mOwner] = iTready;
      expLast          = iTlast[mOwner] || (mCnt == MAXB - 1);
      expTrunc         = expValid && iTready && expLast && !iTlast[mOwner];
    end
    checkVal("tvalid", 32'(oTvalid), 32'(expValid));
    checkVal("tready", 32'(oTready), 32'(expReady));
    checkVal("tid", 32'(oTid), 32'(expTid));
    checkVal("trunc", 32'(oTrunc), 32'(expTrunc));
    if (expValid) begin
      checkVal("tdata", 32'(oTdata), 32'(iTdata[8*mOwner +: 8]));
      checkVal("tlast", 32'(oTlast), 32'(expLast));
    end
    if (oTvalid === 1'b1 && iTready) begin
      k = int'(oTid);
      if (prevLast) pktStarts.push_back(k);
      xferTid.push_back(k);
      xferCycle.push_back(cycleNo);
      xferData.push_back(oTdata);
      xferLast.push_back(oTlast);
      prevLast = oTlast;
      if (oTrunc === 1'b1) truncCount++;
      if (k < N && head[k] < tail[k]) checkVal("sb_data", 32'(oTdata), 32'(srcMem[k][head[k]][7:0]));
    end
    for (int j = 0; j < N; j++) if (iTvalid[j] && oTready[j] === 1'b1) head[j]++;
  endtask

  task automatic modelAdvance();
    int p;
    if (mOwner < 0) begin
      p = rrPick(mLastGrant, iTvalid);
      if (p >= 0) begin
        mOwner = p;
        mCnt   = 0;
      end
    end else if (iTvalid[mOwner] && iTready) begin
      if (iTlast[mOwner] || mCnt == MAXB - 1) begin
        mLastGrant = mOwner;
        mOwner     = -1;
      end
      mCnt++;
    end
  endtask

  task automatic stepCycle();
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    modelAdvance();
    cycleNo++;
  endtask

  task automatic runUntilDrained(input int maxCyc, input string tag);
    int c = 0;
    while (!drained() && c < maxCyc) begin
      stepCycle();
      c++;
    end
    repeat (3) stepCycle();
    checkVal({tag, "_drain"}, 32'(drained()), 32'd1);
  endtask

  initial begin
    int guard, cnt[N], mx, mn, expLasts, expTruncs, len;
    rstN = 1'b0; iTvalid = '0; iTlast = '0; iTdata = '0; iTready = 1'b1;
    gapPct = 0; readyMode = 0; readyToggle = 1'b1;
    clearSources(); clearLog(); modelReset();

    #12;
    checkVal("rst_tvalid", 32'(oTvalid), 32'd0);
    checkVal("rst_tready", 32'(oTready), 32'd0);
    checkVal("rst_tid", 32'(oTid), 32'(N - 1));
    checkVal("rst_trunc", 32'(oTrunc), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] reset priority");
    clearLog();
    for (int k = 0; k < N; k++) pushPacket(k, 2, 1'b0, 8'(16 * k));
    runUntilDrained(40, "rr");
    checkVal("rr_pkts", 32'(pktStarts.size()), 32'd4);
    if (pktStarts.size() == 4) for (int i = 0; i < 4; i++) checkVal("rr_tid_seq", 32'(pktStarts[i]), 32'(i));
    checkVal("rr_beats", 32'(xferLast.size()), 32'd8);
    if (xferLast.size() == 8) for (int i = 0; i < 8; i++) checkVal("rr_last", 32'(xferLast[i]), 32'(i % 2));

    $display("[TB] stream order");
    clearLog();
    pushPacket(2, 3, 1'b0, 8'hA0);
    guard = 0;
    while (xferTid.size() < 1 && guard < 10) begin
      stepCycle();
      guard++;
    end
    checkVal("order_first", 32'(xferTid.size() >= 1), 32'd1);
    pushPacket(1, 2, 1'b0, 8'hB0);
    runUntilDrained(40, "order");
    checkVal("order_beats", 32'(xferData.size()), 32'd5);
    if (xferData.size() == 5) begin
      for (int i = 0; i < 3; i++) checkVal("order_data", 32'(xferData[i]), 32'(8'hA0 + i));
      checkVal("order_tid2", 32'(xferTid[2]), 32'd2);
      checkVal("order_tid1", 32'(xferTid[3]), 32'd1);
      checkVal("order_gap", 32'(xferCycle[3] - xferCycle[2]), 32'd2);
    end

    $display("[TB] backpressure");
    clearLog();
    readyMode = 2; readyToggle = 1'b1;
    pushPacket(1, 4, 1'b0, 8'h30);
    runUntilDrained(40, "bp");
    checkVal("bp_beats", 32'(xferData.size()), 32'd4);
    if (xferData.size() == 4) for (int i = 0; i < 4; i++) checkVal("bp_data", 32'(xferData[i]), 32'(8'h30 + i));
    readyMode = 0;

    $display("[TB] truncation");
    clearLog();
    pushPacket(3, 6, 1'b0, 8'h60);
    runUntilDrained(40, "trunc");
    checkVal("trunc_count", 32'(truncCount), 32'd1);
    checkVal("trunc_beats", 32'(xferLast.size()), 32'd6);
    if (xferLast.size() == 6) for (int i = 0; i < 6; i++) checkVal("trunc_last", 32'(xferLast[i]), 32'(i == 3 || i == 5));
    checkVal("trunc_grants", 32'(pktStarts.size()), 32'd2);

    $display("[TB] async reset");
    clearLog();
    pushPacket(0, 4, 1'b0, 8'h00);
    guard = 0;
    while (xferTid.size() < 1 && guard < 10) begin
      stepCycle();
      guard++;
    end
    checkVal("ar_started", 32'(xferTid.size() >= 1), 32'd1);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkVal("ar_tvalid", 32'(oTvalid), 32'd0);
    checkVal("ar_tready", 32'(oTready), 32'd0);
    checkVal("ar_tid", 32'(oTid), 32'(N - 1));
    iTvalid = '0;
    modelReset(); clearSources(); clearLog();
    pushPacket(0, 1, 1'b0, 8'hC0);
    pushPacket(2, 1, 1'b0, 8'hC2);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    runUntilDrained(20, "ar");
    checkVal("ar_pkts", 32'(pktStarts.size()), 32'd2);
    if (pktStarts.size() == 2) checkVal("ar_first_grant", 32'(pktStarts[0]), 32'd0);

    $display("[TB] fairness");
    clearLog(); clearSources();
    for (int p = 0; p < 25; p++) for (int k = 0; k < N; k++) pushPacket(k, 1, 1'b1, 8'h00);
    runUntilDrained(400, "fair");
    for (int k = 0; k < N; k++) cnt[k] = 0;
    foreach (xferTid[i]) if (xferTid[i] < N) cnt[xferTid[i]]++;
    mx = cnt[0]; mn = cnt[0];
    for (int k = 1; k < N; k++) begin
      if (cnt[k] > mx) mx = cnt[k];
      if (cnt[k] < mn) mn = cnt[k];
    end
    checkVal("fair_spread", 32'((mx - mn) <= 1), 32'd1);
    checkVal("fair_total", 32'(xferTid.size()), 32'd100);

    $display("[TB] random traffic");
    clearLog(); clearSources();
    expLasts = 0; expTruncs = 0;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < int'($urandom_range(1, 6)); p++) begin
        len = $urandom_range(1, 7);
        pushPacket(k, len, 1'b1, 8'h00);
        expLasts  += (len + MAXB - 1) / MAXB;
        expTruncs += (len + MAXB - 1) / MAXB - 1;
      end
    end
    gapPct = 25; readyMode = 1;
    runUntilDrained(2000, "rand");
    mx = 0;
    foreach (xferLast[i]) if (xferLast[i]) mx++;
    checkVal("rand_lasts", 32'(mx), 32'(expLasts));
    checkVal("rand_truncs", 32'(truncCount), 32'(expTruncs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of AXI-stream requesters (2..8).
REQ-002 The block SHALL have parameter MAX_BEATS, default 256, giving the beats forwarded per grant before a forced packet end (1..65535).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_tdata, input, 8*N bits: requester k data in bits [8k+7:8k].
REQ-006 The block SHALL have port i_tlast, input, N bits: per-requester end of packet.
REQ-007 The block SHALL have port i_tvalid, input, N bits: per-requester beat valid.
REQ-008 The block SHALL have port o_tready, output, N bits: per-requester beat accepted.
REQ-009 The block SHALL have port o_tdata, output, 8 bits: merged stream data.
REQ-010 The block SHALL have port o_tlast, output, 1 bit: merged stream end of packet.
REQ-011 The block SHALL have port o_tvalid, output, 1 bit: merged stream valid.
REQ-012 The block SHALL have port i_tready, input, 1 bit: downstream ready.
REQ-013 The block SHALL have port o_tid, output, clog2(N) bits: index of the requester currently granted.
REQ-014 The block SHALL have port o_trunc, output, 1 bit: one-cycle pulse when a packet is force-ended.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and BUSY.
REQ-016 In IDLE, o_tvalid and all o_tready bits SHALL be 0.
REQ-017 In IDLE with any i_tvalid high, the block SHALL grant round-robin, searching from (last_grant+1) mod N upward with wrap-around, and enter BUSY the next cycle.
REQ-018 The grant decision SHALL cost exactly one cycle; the first beat is forwarded no earlier than the cycle after the decision.
REQ-019 In BUSY, for granted g, the block SHALL set o_tdata=i_tdata[g], o_tvalid=i_tvalid[g] and o_tready[g]=i_tready combinationally, with all other o_tready bits 0.
REQ-020 In BUSY, o_tlast SHALL equal i_tlast[g] OR (beat_cnt == MAX_BEATS-1).
REQ-021 A beat SHALL transfer only when o_tvalid and i_tready are both high.
REQ-022 The beat counter SHALL be 16 bits, cleared on entering BUSY, and incremented per transferred beat.
REQ-023 A transferred beat with o_tlast high SHALL return the FSM to IDLE and set last_grant=g.
REQ-024 If such a beat has i_tlast[g]=0 (forced end), the block SHALL pulse o_trunc for that cycle, and the rest of the packet SHALL compete as a new packet.
REQ-025 An i_tvalid[g] drop mid-packet SHALL hold the grant indefinitely; there is no timeout.
REQ-026 Requests arriving while BUSY SHALL wait; the grant SHALL never change before a transferred o_tlast beat.
REQ-027 o_tid SHALL hold the current grant in BUSY and last_grant in IDLE.
REQ-028 With only one requester active, back-to-back packets SHALL incur exactly one idle cycle between them.

Reset
REQ-029 Asserting i_rst_n low SHALL immediately force: FSM=IDLE, beat_cnt=0, last_grant=N-1, o_tvalid=0, o_tready=0, o_trunc=0, o_tid=N-1.
REQ-030 As a consequence of REQ-029, requester 0 SHALL have first priority after reset.
REQ-031 Reset mid-packet SHALL abandon the packet with no o_tlast emitted, and the block SHALL resume arbitration on the first clock edge after deassertion.

Verification
REQ-032 Bench scenario, reset priority: reset, then i_tvalid=4'b1111, each requester sends a 2-beat packet -> o_tid sequence 0,1,2,3 and 8 beats out, each pair tlast-terminated.
REQ-033 Bench scenario, stream order: requester 2 sends 3 beats A0,A1,A2 (last on A2) while requester 1 asserts valid after beat 1 -> output A0,A1,A2 from tid 2, then requester 1's packet after one idle cycle.
REQ-034 Bench scenario, backpressure: i_tready toggles 1,0,1,0 during a 4-beat packet -> each beat appears exactly once and o_tready[g] mirrors i_tready.
REQ-035 Bench scenario, truncation: MAX_BEATS=4, 6-beat packet -> beat 4 carries o_tlast=1 with o_trunc=1, then beats 5-6 follow as a new grant ending on the true tlast.
REQ-036 Bench scenario, async reset: assert i_rst_n low mid-beat between clock edges -> o_tvalid=0 and o_tready=0 immediately, and after release the next grant goes to requester 0 if valid.
REQ-037 Bench scenario, fairness: hold all N requesters valid with 1-beat packets for 100 packets -> per-requester counts differ by at most 1.
